// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Owner encoding is also the payload stored in the outstanding-ID FIFO.
package mem_arb_pkg;

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_e;

    localparam logic [3:0] MEM_BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Small circular FIFO remembering which requester owns each
// outstanding memory transaction; responses return in order.
module mem_arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            mem_d[wr_q] = wdata_i;
            wr_d        = ptr_inc(wr_q);
        end
        if (pop_i) begin
            rd_d = ptr_inc(rd_q);
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instr and data sides.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties (default DATA wins).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        orphan_rsp_o
);

    localparam int ID_W = $clog2(MAX_OUTSTANDING) + 1;

    lock_e        lock_q, lock_d;
    owner_e       owner_q, owner_d;
    owner_e       sel_owner, tie_owner, head_owner;
    logic         sel_valid;
    logic         push, pop;
    logic         fifo_full, fifo_empty;
    logic [0:0]   fifo_rdata;
    logic [ID_W-1:0] fifo_cnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e rr_last_q, rr_last_d;

    assign tie_owner = (rr_last_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
    assign rr_last_d = push ? sel_owner : rr_last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_last_q <= OWNER_INSTR;
        else      rr_last_q <= rr_last_d;
    end
`else
    assign tie_owner = OWNER_DATA;
`endif

    // A held lock pins the selection so address/data never switch mid-request.
    always_comb begin
        sel_owner = OWNER_DATA;
        sel_valid = 1'b0;
        if (lock_q == LOCK_HELD) begin
            sel_owner = owner_q;
            sel_valid = (owner_q == OWNER_DATA) ? data_req_i : instr_req_i;
        end else if (data_req_i && instr_req_i) begin
            sel_owner = tie_owner;
            sel_valid = 1'b1;
        end else if (data_req_i) begin
            sel_owner = OWNER_DATA;
            sel_valid = 1'b1;
        end else if (instr_req_i) begin
            sel_owner = OWNER_INSTR;
            sel_valid = 1'b1;
        end
    end

    always_comb begin
        mem_req_o   = rst & sel_valid & ~fifo_full;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (mem_req_o) begin
            if (sel_owner == OWNER_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = MEM_BE_FULL;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    always_comb begin
        lock_d  = (mem_req_o && !mem_gnt_i) ? LOCK_HELD : LOCK_IDLE;
        owner_d = mem_req_o ? sel_owner : owner_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q  <= LOCK_IDLE;
            owner_q <= OWNER_DATA;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    assign push = mem_req_o & mem_gnt_i;
    assign pop  = rst & mem_rvalid_i & ~fifo_empty;

    mem_arb_id_fifo #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(1)
    ) u_id_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (push),
        .wdata_i(sel_owner),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_cnt)
    );

    assign head_owner = owner_e'(fifo_rdata);

    assign instr_gnt_o    = push & (sel_owner == OWNER_INSTR);
    assign data_gnt_o     = push & (sel_owner == OWNER_DATA);
    assign instr_rvalid_o = pop & (head_owner == OWNER_INSTR);
    assign data_rvalid_o  = pop & (head_owner == OWNER_DATA);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
    assign instr_err_o    = instr_rvalid_o & mem_err_i;
    assign data_err_o     = data_rvalid_o & mem_err_i;
    assign orphan_rsp_o   = rst & mem_rvalid_i & (fifo_cnt == '0);

endmodule
